// File: rtl/mul_sequencer.sv
// Sequences one signed multiply: accept, pulse start, wait for done or time out, then hold result for writeback.
// Latency: wb_valid rises k+1 cycles after mul_start when mul_done arrives k cycles after it; one request in flight.
module mul_sequencer #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    input  logic [2:0]  req_dst,
    output logic        mul_start,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic        mul_done,
    input  logic [15:0] mul_lo,
    input  logic [15:0] mul_hi,
    input  logic        mul_z,
    input  logic        mul_n,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [2:0]  wb_dst,
    output logic [15:0] wb_lo,
    output logic [15:0] wb_hi,
    output logic        wb_z,
    output logic        wb_n,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic [2:0]  dst_q, dst_d;
    logic [15:0] lo_q, lo_d, hi_q, hi_d;
    logic        z_q, z_d, n_q, n_d;
    logic        terr_q, terr_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dst_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dst_q   <= dst_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            z_q     <= z_d;
            n_q     <= n_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        dst_d   = dst_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        z_d     = z_q;
        n_d     = n_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    dst_d   = req_dst;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                // done is checked first so a result on the last allowed cycle still wins
                if (mul_done) begin
                    lo_d    = mul_lo;
                    hi_d    = mul_hi;
                    z_d     = mul_z;
                    n_d     = mul_n;
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    terr_d  = 1'b1;
                    lo_d    = '0;
                    hi_d    = '0;
                    z_d     = 1'b1;
                    n_d     = 1'b0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign mul_start   = (state_q == START);
    assign wb_valid    = (state_q == HOLD);
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign wb_dst      = dst_q;
    assign wb_lo       = lo_q;
    assign wb_hi       = hi_q;
    assign wb_z        = z_q;
    assign wb_n        = n_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: default-timeout and TIMEOUT=8 instances share stimulus, one selected at a time.
// Expected writeback records are queued at request time and popped at the writeback handshake.
module tb_mul_sequencer;

    typedef struct {
        logic [2:0]  dst;
        logic [15:0] lo;
        logic [15:0] hi;
        logic        z;
        logic        n;
    } exp_t;

    logic        clk, rst, sel;
    logic        req_valid, mul_done, wb_ready;
    logic [15:0] req_a, req_b, mul_lo, mul_hi;
    logic [2:0]  req_dst;
    logic        mul_z, mul_n;

    logic        req_ready_w[2], mul_start_w[2], wb_valid_w[2];
    logic        wb_z_w[2], wb_n_w[2], busy_w[2], terr_w[2];
    logic [15:0] mul_a_w[2], mul_b_w[2], wb_lo_w[2], wb_hi_w[2];
    logic [2:0]  wb_dst_w[2];

    logic        req_ready, mul_start, wb_valid, wb_z, wb_n, busy, timeout_err;
    logic [15:0] mul_a, mul_b, wb_lo, wb_hi;
    logic [2:0]  wb_dst;

    exp_t sb[$];
    logic exp_terr[2];
    int   n_checks = 0;
    int   n_fail   = 0;

    mul_sequencer dut40 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel), .req_ready(req_ready_w[0]),
        .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
        .mul_start(mul_start_w[0]), .mul_a(mul_a_w[0]), .mul_b(mul_b_w[0]),
        .mul_done(mul_done & ~sel), .mul_lo(mul_lo), .mul_hi(mul_hi),
        .mul_z(mul_z), .mul_n(mul_n),
        .wb_valid(wb_valid_w[0]), .wb_ready(wb_ready & ~sel),
        .wb_dst(wb_dst_w[0]), .wb_lo(wb_lo_w[0]), .wb_hi(wb_hi_w[0]),
        .wb_z(wb_z_w[0]), .wb_n(wb_n_w[0]),
        .busy(busy_w[0]), .timeout_err(terr_w[0])
    );

    mul_sequencer #(.TIMEOUT(8)) dut8 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel), .req_ready(req_ready_w[1]),
        .req_a(req_a), .req_b(req_b), .req_dst(req_dst),
        .mul_start(mul_start_w[1]), .mul_a(mul_a_w[1]), .mul_b(mul_b_w[1]),
        .mul_done(mul_done & sel), .mul_lo(mul_lo), .mul_hi(mul_hi),
        .mul_z(mul_z), .mul_n(mul_n),
        .wb_valid(wb_valid_w[1]), .wb_ready(wb_ready & sel),
        .wb_dst(wb_dst_w[1]), .wb_lo(wb_lo_w[1]), .wb_hi(wb_hi_w[1]),
        .wb_z(wb_z_w[1]), .wb_n(wb_n_w[1]),
        .busy(busy_w[1]), .timeout_err(terr_w[1])
    );

    assign req_ready   = req_ready_w[sel];
    assign mul_start   = mul_start_w[sel];
    assign wb_valid    = wb_valid_w[sel];
    assign wb_z        = wb_z_w[sel];
    assign wb_n        = wb_n_w[sel];
    assign busy        = busy_w[sel];
    assign timeout_err = terr_w[sel];
    assign mul_a       = mul_a_w[sel];
    assign mul_b       = mul_b_w[sel];
    assign wb_lo       = wb_lo_w[sel];
    assign wb_hi       = wb_hi_w[sel];
    assign wb_dst      = wb_dst_w[sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk_eq(input string tag, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Full transaction; delay=0 means the multiplier never answers.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] dst,
                          input int delay, input int hold);
        exp_t e, got_e;
        logic signed [31:0] p, mp;
        int cyc, tmo, exp_lat;
        logic timed_out;
        tmo       = sel ? 8 : 40;
        timed_out = (delay == 0) || (delay > tmo);
        p         = $signed(a) * $signed(b);
        if (timed_out) e = '{dst, 16'h0000, 16'h0000, 1'b1, 1'b0};
        else           e = '{dst, p[15:0], p[31:16], (p == 0), p[31]};
        sb.push_back(e);
        if (timed_out) exp_terr[sel] = 1'b1;
        exp_lat = timed_out ? tmo + 1 : delay + 1;

        @(negedge clk);
        chk_eq("req_ready_idle", 40'(req_ready), 40'(1));
        req_valid = 1'b1; req_a = a; req_b = b; req_dst = dst;
        @(negedge clk);
        req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom); req_dst = 3'($urandom);
        chk_eq("mul_start", 40'(mul_start), 40'(1));
        chk_eq("mul_ab_start", 40'({mul_a, mul_b}), 40'({a, b}));
        chk_eq("busy", 40'(busy), 40'(1));
        chk_eq("req_ready_start", 40'(req_ready), 40'(0));

        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (wb_valid) break;
            if (cyc == 1) chk_eq("start_single_pulse", 40'(mul_start), 40'(0));
            mul_done = (cyc == delay);
            if (mul_done) begin
                mp     = $signed(mul_a) * $signed(mul_b);
                mul_lo = mp[15:0];
                mul_hi = mp[31:16];
                mul_z  = (mp == 0);
                mul_n  = mp[31];
            end else begin
                mul_lo = 16'($urandom); mul_hi = 16'($urandom);
                mul_z  = 1'($urandom);  mul_n  = 1'($urandom);
            end
        end
        mul_done = 1'b0;
        chk_eq("latency", 40'(cyc), 40'(exp_lat));

        for (int h = 0; h < hold; h++) begin
            chk_eq("hold_stable", 40'({wb_valid, wb_z, wb_n, wb_dst, wb_hi, wb_lo}),
                   40'({1'b1, e.z, e.n, e.dst, e.hi, e.lo}));
            chk_eq("req_ready_hold", 40'(req_ready), 40'(0));
            req_valid = (h == 2);
            mul_done  = (h == 4);
            @(negedge clk);
        end
        req_valid = 1'b0;
        mul_done  = 1'b0;

        chk_eq("wb_valid", 40'(wb_valid), 40'(1));
        wb_ready = 1'b1;
        got_e = sb.pop_front();
        chk_eq("wb_dst", 40'(wb_dst), 40'(got_e.dst));
        chk_eq("wb_lo",  40'(wb_lo),  40'(got_e.lo));
        chk_eq("wb_hi",  40'(wb_hi),  40'(got_e.hi));
        chk_eq("wb_zn",  40'({wb_z, wb_n}), 40'({got_e.z, got_e.n}));
        chk_eq("timeout_err", 40'(timeout_err), 40'(exp_terr[sel]));
        chk_eq("mul_ab_hold", 40'({mul_a, mul_b}), 40'({a, b}));
        @(negedge clk);
        wb_ready = 1'b0;
        chk_eq("wb_valid_after", 40'(wb_valid), 40'(0));
        chk_eq("req_ready_after", 40'(req_ready), 40'(1));
    endtask

    task automatic reset_mid_wait();
        logic seen;
        @(negedge clk);
        req_valid = 1'b1; req_a = 16'd11; req_b = 16'd13; req_dst = 3'd4;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_terr[0] = 1'b0;
        exp_terr[1] = 1'b0;
        chk_eq("rst_mid_busy", 40'(busy), 40'(0));
        mul_done = 1'b1; mul_lo = 16'd143; mul_hi = 16'd0; mul_z = 1'b0; mul_n = 1'b0;
        @(negedge clk);
        mul_done = 1'b0;
        chk_eq("rst_mid_req_ready", 40'(req_ready), 40'(1));
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (wb_valid || busy) seen = 1'b1;
        end
        chk_eq("rst_mid_no_wb", 40'(seen), 40'(0));
    endtask

    initial begin
        sel = 1'b0; rst = 1'b0;
        req_valid = 1'b0; req_a = '0; req_b = '0; req_dst = '0;
        mul_done = 1'b0; mul_lo = '0; mul_hi = '0; mul_z = 1'b0; mul_n = 1'b0;
        wb_ready = 1'b0;
        exp_terr[0] = 1'b0; exp_terr[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        chk_eq("rst_ctrl", 40'({busy, req_ready, mul_start, wb_valid, timeout_err}), 40'(5'b01000));
        chk_eq("rst_data", 40'({mul_a, mul_b}), 40'(0));
        chk_eq("rst_wb", 40'({wb_dst, wb_hi, wb_lo, wb_z, wb_n}), 40'(0));

        run_op(16'd3, 16'hFFFE, 3'd5, 16, 10);
        run_op(16'h8000, 16'h8000, 3'd2, 3, 0);
        run_op(16'd0, 16'h1234, 3'd7, 1, 1);
        for (int i = 0; i < 4; i++)
            run_op(16'($urandom), 16'($urandom), 3'($urandom), $urandom_range(1, 30), 2);

        reset_mid_wait();

        sel = 1'b1;
        run_op(16'd5, 16'hFFFC, 3'd3, 8, 0);
        run_op(16'd7, 16'd9, 3'd1, 0, 3);
        run_op(16'd100, 16'd200, 3'd6, 3, 0);
        run_op(16'hFFFF, 16'hFFFF, 3'd0, 7, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
